sha256_xmss_padder: RTL and testbench

Message-padding and block-sequencing stage between the 1024-bit XMSS input message register and the SHA-256 compression core. It accepts a 768-bit or 1024-bit message in one transfer, appends standard SHA-256 padding, and emits the resulting 512-bit blocks in order over a valid/ready handshake. A skip option omits block 0 when the core resumes from a stored intermediate state.

---
 rtl/sha256_xmss_padder.sv | 172 +++++++++++++++++
 tb/tb_sha256_xmss_padder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_xmss_padder.sv
// ---------------------------------------------------------------------------
// sha256_xmss_padder
//
// Takes one 768-bit or 1024-bit message, applies SHA-256 padding, and sends
// the resulting 512-bit blocks in order to the compression core over a
// valid/ready handshake. When skip_first is set, block 0 is not sent because
// the core resumes from a stored intermediate state.
//
// Ports:
//   io_mainClk      - clock; all state updates happen on the rising edge
//   io_systemReset  - synchronous, active-low reset
//   msg_data        - message; bit 1023 is the first bit (big-endian)
//   msg_len_sel     - 0 = 768-bit message, 1 = 1024-bit message
//   skip_first      - block 0 already absorbed; do not emit it
//   msg_valid       - message transfer request (sampled only in IDLE)
//   msg_ready       - padder idle and able to accept a message
//   blk_data        - current 512-bit block, MSB first (registered)
//   blk_first       - current block is block 0 (registered)
//   blk_last        - current block is the final block (registered)
//   blk_valid       - blk_* outputs valid (registered)
//   blk_ready       - core accepts the current block
//   flush           - synchronous abort to IDLE; wins over any handshake
//   busy            - high whenever the padder is not idle
// ---------------------------------------------------------------------------
module sha256_xmss_padder #(
    parameter logic [31:0] LEN_OFFSET = 32'd0
) (
    input  logic          io_mainClk,
    input  logic          io_systemReset,
    input  logic [1023:0] msg_data,
    input  logic          msg_len_sel,
    input  logic          skip_first,
    input  logic          msg_valid,
    output logic          msg_ready,
    output logic [511:0]  blk_data,
    output logic          blk_first,
    output logic          blk_last,
    output logic          blk_valid,
    input  logic          blk_ready,
    input  logic          flush,
    output logic          busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t          state_r,     state_s;
    logic [1023:0]   msg_r,       msg_s;
    logic            len_sel_r,   len_sel_s;
    logic [1:0]      blk_idx_r,   blk_idx_s;
    logic [511:0]    blk_data_r,  blk_data_s;
    logic            blk_first_r, blk_first_s;
    logic            blk_last_r,  blk_last_s;
    logic            blk_valid_r, blk_valid_s;

    // Index of the final block: two blocks for 768 bits, three for 1024 bits.
    function automatic logic [1:0] last_idx(input logic ls);
        return ls ? 2'd2 : 2'd1;
    endfunction

    // Padded block number idx of message m. The length field is the message
    // bit length plus LEN_OFFSET, widened to 64 bits so it cannot overflow.
    function automatic logic [511:0] block_of(input logic [1023:0] m,
                                              input logic          ls,
                                              input logic [1:0]    idx);
        logic [63:0]  lf;
        logic [511:0] b;
        lf = (ls ? 64'd1024 : 64'd768) + {32'd0, LEN_OFFSET};
        case (idx)
            2'd0:    b = m[1023:512];
            2'd1:    b = ls ? m[511:0] : {m[511:256], 1'b1, 191'd0, lf};
            2'd2:    b = {1'b1, 447'd0, lf};
            default: b = 512'd0;
        endcase
        return b;
    endfunction

    // State register and registered block outputs; reset overrides everything.
    always_ff @(posedge io_mainClk) begin
        if (!io_systemReset) begin
            state_r     <= ST_IDLE;
            msg_r       <= 1024'd0;
            len_sel_r   <= 1'b0;
            blk_idx_r   <= 2'd0;
            blk_data_r  <= 512'd0;
            blk_first_r <= 1'b0;
            blk_last_r  <= 1'b0;
            blk_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            msg_r       <= msg_s;
            len_sel_r   <= len_sel_s;
            blk_idx_r   <= blk_idx_s;
            blk_data_r  <= blk_data_s;
            blk_first_r <= blk_first_s;
            blk_last_r  <= blk_last_s;
            blk_valid_r <= blk_valid_s;
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_s     = state_r;
        msg_s       = msg_r;
        len_sel_s   = len_sel_r;
        blk_idx_s   = blk_idx_r;
        blk_data_s  = blk_data_r;
        blk_first_s = blk_first_r;
        blk_last_s  = blk_last_r;
        blk_valid_s = blk_valid_r;

        if (flush) begin
            // Abort: no capture, no advance. blk_data is left as-is since it
            // is meaningless without blk_valid.
            state_s     = ST_IDLE;
            blk_idx_s   = 2'd0;
            blk_valid_s = 1'b0;
            blk_first_s = 1'b0;
            blk_last_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (msg_valid) begin
                        msg_s       = msg_data;
                        len_sel_s   = msg_len_sel;
                        blk_idx_s   = skip_first ? 2'd1 : 2'd0;
                        blk_data_s  = block_of(msg_data, msg_len_sel,
                                               skip_first ? 2'd1 : 2'd0);
                        blk_first_s = ~skip_first;
                        // With skip on a 768-bit message the only emitted
                        // block is also the last one.
                        blk_last_s  = skip_first & ~msg_len_sel;
                        blk_valid_s = 1'b1;
                        state_s     = ST_EMIT;
                    end else begin
                        state_s     = ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (blk_ready && blk_last_r) begin
                        state_s     = ST_IDLE;
                        blk_valid_s = 1'b0;
                        blk_first_s = 1'b0;
                        blk_last_s  = 1'b0;
                    end else if (blk_ready) begin
                        blk_idx_s   = blk_idx_r + 2'd1;
                        blk_data_s  = block_of(msg_r, len_sel_r, blk_idx_r + 2'd1);
                        blk_first_s = 1'b0;
                        blk_last_s  = ((blk_idx_r + 2'd1) == last_idx(len_sel_r));
                    end else begin
                        // Backpressure: hold the presented block unchanged.
                        state_s     = ST_EMIT;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    blk_valid_s = 1'b0;
                end
            endcase
        end
    end

    assign msg_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign blk_data  = blk_data_r;
    assign blk_first = blk_first_r;
    assign blk_last  = blk_last_r;
    assign blk_valid = blk_valid_r;

endmodule

// File: tb/tb_sha256_xmss_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_xmss_padder
//
// Drives two padder instances (LEN_OFFSET 0 and 512) with identical stimulus
// and compares every presented block against a reference that builds the
// full padded message as one bit string and slices it into 512-bit blocks.
// ---------------------------------------------------------------------------
module tb_sha256_xmss_padder;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] msg_data;
    logic          msg_len_sel;
    logic          skip_first;
    logic          msg_valid;
    logic          blk_ready;
    logic          flush;

    logic          mready0, mready1, valid0, valid1;
    logic          first0, first1, last0, last1, busy0, busy1;
    logic [511:0]  data0, data1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_xmss_padder #(.LEN_OFFSET(32'd0)) dut0 (
        .io_mainClk(clk), .io_systemReset(rst_n), .msg_data(msg_data),
        .msg_len_sel(msg_len_sel), .skip_first(skip_first), .msg_valid(msg_valid),
        .msg_ready(mready0), .blk_data(data0), .blk_first(first0), .blk_last(last0),
        .blk_valid(valid0), .blk_ready(blk_ready), .flush(flush), .busy(busy0));

    sha256_xmss_padder #(.LEN_OFFSET(32'd512)) dut1 (
        .io_mainClk(clk), .io_systemReset(rst_n), .msg_data(msg_data),
        .msg_len_sel(msg_len_sel), .skip_first(skip_first), .msg_valid(msg_valid),
        .msg_ready(mready1), .blk_data(data1), .blk_first(first1), .blk_last(last1),
        .blk_valid(valid1), .blk_ready(blk_ready), .flush(flush), .busy(busy1));

    // Reference: message bits, a single 1 bit, zeros, then the 64-bit length,
    // padded to a multiple of 512 bits; block k is the k-th 512-bit slice.
    function automatic logic [511:0] model_blk(input logic [1023:0] m, input logic ls,
                                               input int k, input int unsigned off);
        int          len;
        int          total;
        logic [1535:0] p;
        logic [63:0] lf;
        len   = ls ? 1024 : 768;
        total = ((len + 65 + 511) / 512) * 512;
        p     = '0;
        lf    = 64'(len) + 64'(off);
        for (int i = 0; i < len; i++) p[1535 - i] = m[1023 - i];
        p[1535 - len] = 1'b1;
        p[1536 - total +: 64] = lf;
        return p[1535 - 512 * k -: 512];
    endfunction

    function automatic int model_nblk(input logic ls);
        return ls ? 3 : 2;
    endfunction

    function automatic logic [1023:0] rand_msg();
        logic [1023:0] m;
        for (int i = 0; i < 32; i++) m[32 * i +: 32] = $urandom;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check both instances are idle.
    task automatic check_idle(input string name);
        checks++;
        if (mready0 !== 1'b1 || mready1 !== 1'b1 || valid0 !== 1'b0 || valid1 !== 1'b0 ||
            busy0 !== 1'b0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL %s: mready=%b%b valid=%b%b busy=%b%b required mready=11 valid=00 busy=00",
                     name, mready0, mready1, valid0, valid1, busy0, busy1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; msg_valid = 1'b0; blk_ready = 1'b0; flush = 1'b0;
        msg_data = '0; msg_len_sel = 1'b0; skip_first = 1'b0;
        step(); step();
        rst_n = 1'b1;
        checks++;
        if (data0 !== 512'd0 || data1 !== 512'd0 || first0 !== 1'b0 || last0 !== 1'b0 ||
            first1 !== 1'b0 || last1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: data0_zero=%b first=%b%b last=%b%b required all zero",
                     data0 == 512'd0, first0, first1, last0, last1);
        end
        check_idle("reset_idle");
    endtask

    // Send one message and consume every block. bp: 0 = ready always high,
    // 1 = random ready, 2 = ready low for 5 cycles on each block.
    task automatic run_msg(input logic [1023:0] m, input logic ls, input logic sk,
                           input int bp, input string name);
        int nblk, k, cycles, wait_cnt, budget;
        logic rdy;
        logic [511:0] e0, e1;
        nblk = model_nblk(ls);
        k = sk ? 1 : 0;
        check_idle({name, "_ready_before"});
        msg_data = m; msg_len_sel = ls; skip_first = sk; msg_valid = 1'b1; blk_ready = 1'b0;
        step();
        cycles = 1;
        msg_valid = 1'b0;
        msg_data = rand_msg();
        skip_first = $urandom_range(0, 1);
        msg_len_sel = $urandom_range(0, 1);
        wait_cnt = 0;
        budget = 0;
        while (k < nblk && budget < 200) begin
            budget++;
            e0 = model_blk(m, ls, k, 0);
            e1 = model_blk(m, ls, k, 512);
            checks++;
            if (valid0 !== 1'b1 || valid1 !== 1'b1 || busy0 !== 1'b1 || mready0 !== 1'b0) begin
                failures++;
                $display("FAIL %s_valid blk%0d: valid=%b%b busy=%b mready=%b required valid=11 busy=1 mready=0",
                         name, k, valid0, valid1, busy0, mready0);
            end
            checks++;
            if (data0 !== e0) begin
                failures++;
                $display("FAIL %s_data_off0 blk%0d: got %h required %h", name, k, data0[127:0], e0[127:0]);
            end
            checks++;
            if (data1 !== e1) begin
                failures++;
                $display("FAIL %s_data_off512 blk%0d: got %h required %h", name, k, data1[127:0], e1[127:0]);
            end
            checks++;
            if (first0 !== (k == 0) || first1 !== (k == 0) ||
                last0 !== (k == nblk - 1) || last1 !== (k == nblk - 1)) begin
                failures++;
                $display("FAIL %s_flags blk%0d: first=%b%b last=%b%b required first=%0d last=%0d",
                         name, k, first0, first1, last0, last1, k == 0, k == nblk - 1);
            end
            case (bp)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (wait_cnt >= 5);
            endcase
            blk_ready = rdy;
            msg_valid = 1'($urandom_range(0, 1));
            step();
            cycles++;
            msg_valid = 1'b0;
            if (rdy) begin
                k++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
        blk_ready = 1'b0;
        if (budget >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: consumed %0d blocks required %0d", name, k, nblk);
        end
        check_idle({name, "_idle_after"});
        if (bp == 0) begin
            int exp_cyc;
            exp_cyc = ls ? (sk ? 3 : 4) : (sk ? 2 : 3);
            checks++;
            if (cycles !== exp_cyc) begin
                failures++;
                $display("FAIL %s_cycles: got %0d required %0d", name, cycles, exp_cyc);
            end
        end
    endtask

    task automatic test_directed();
        logic [1023:0] m;
        for (int i = 0; i < 32; i++) m[32 * i +: 32] = 32'h0000_0001;
        run_msg(m, 1'b0, 1'b0, 0, "d768");
        run_msg(rand_msg(), 1'b1, 1'b0, 0, "d1024");
        run_msg(rand_msg(), 1'b1, 1'b1, 0, "d1024_skip");
        run_msg(rand_msg(), 1'b0, 1'b1, 0, "d768_skip");
    endtask

    task automatic test_backpressure();
        run_msg(rand_msg(), 1'b1, 1'b0, 2, "bp1024");
        run_msg(rand_msg(), 1'b0, 1'b0, 2, "bp768");
    endtask

    task automatic test_flush();
        logic [1023:0] m;
        m = rand_msg();
        msg_data = m; msg_len_sel = 1'b1; skip_first = 1'b0; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0; blk_ready = 1'b1;
        step();
        checks++;
        if (valid0 !== 1'b1 || data0 !== model_blk(m, 1'b1, 1, 0)) begin
            failures++;
            $display("FAIL flush_pre_b1: valid=%b data_ok=%b required valid=1 data_ok=1",
                     valid0, data0 === model_blk(m, 1'b1, 1, 0));
        end
        flush = 1'b1; blk_ready = 1'b1; msg_valid = 1'b1;
        step();
        flush = 1'b0; blk_ready = 1'b0; msg_valid = 1'b0;
        check_idle("flush_idle");
        step();
        check_idle("flush_no_capture");
        run_msg(rand_msg(), 1'b0, 1'b0, 0, "after_flush");
    endtask

    task automatic test_reset_mid();
        msg_data = rand_msg(); msg_len_sel = 1'b1; skip_first = 1'b0; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        rst_n = 1'b0; blk_ready = 1'b1;
        step();
        rst_n = 1'b1; blk_ready = 1'b0;
        checks++;
        if (data0 !== 512'd0 || data1 !== 512'd0 || first0 !== 1'b0 || last0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: data0_zero=%b first=%b last=%b required all zero",
                     data0 == 512'd0, first0, last0);
        end
        check_idle("reset_mid_idle");
        run_msg(rand_msg(), 1'b1, 1'b0, 1, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            run_msg(rand_msg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), "rnd");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
